// File: rtl/t1_run_sequencer.sv
// t1_run_sequencer: releases DUT reset, counts run cycles, arbitrates end-of-run and flags errors.
// Optional trace window (dump_start/dump_end, error code 3) is built when T1_RUN_TRACE_WINDOW_EN is defined.
module t1_run_sequencer #(
   parameter int RESET_CYCLES   = 4,
   parameter int CYCLE_W        = 64,
   parameter int PROGRESS_LIMIT = 100000,
   parameter int DRAIN_CYCLES   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               wd_valid,
   input  logic [7:0]         wd_status,
   input  logic               tb_done,
   input  logic               progress,
   input  logic [CYCLE_W-1:0] dump_start,
   input  logic [CYCLE_W-1:0] dump_end,
   output logic               dut_reset,
   output logic               run_active,
   output logic               dump_enable,
   output logic               finish,
   output logic               fatal,
   output logic [1:0]         error_code,
   output logic [CYCLE_W-1:0] cycle
);
   localparam int HOLD_W  = (RESET_CYCLES > 32'sd1) ? $clog2(RESET_CYCLES) : 32'sd1;
   localparam int IDLE_W  = (PROGRESS_LIMIT > 32'sd1) ? $clog2(PROGRESS_LIMIT) : 32'sd1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 32'sd1) ? $clog2(DRAIN_CYCLES) : 32'sd1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 32'sd1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(PROGRESS_LIMIT - 32'sd1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 32'sd1);
   localparam logic               PROG_EN    = (PROGRESS_LIMIT > 32'sd0);
   localparam logic [CYCLE_W-1:0] CYC_MAX    = {CYCLE_W{1'b1}};
   localparam logic [CYCLE_W-1:0] CYC_ZERO   = {CYCLE_W{1'b0}};

   typedef enum logic [2:0] {
      ST_HOLD  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [HOLD_W-1:0]    hold_cnt_r;
   logic [IDLE_W-1:0]    idle_cnt_r;
   logic [DRAIN_W-1:0]   drain_cnt_r;
   logic                 tb_done_seen_r;
   logic [CYCLE_W-1:0]   cycle_r, cycle_s;
   logic [1:0]           err_code_s;
   logic                 wd_bad_s, wd_fin_s, idle_hit_s, end_hit_s, dump_nxt_s;
   logic                 dut_reset_r, run_active_r, dump_enable_r, finish_r, fatal_r;
   logic [1:0]           error_code_r;

`ifdef T1_RUN_TRACE_WINDOW_EN
   logic [CYCLE_W-1:0]   win_start_r, win_end_r, win_start_s, win_end_s;

   // window bounds follow the inputs through HOLD and freeze once the run starts
   always_comb begin
      win_start_s = win_start_r;
      win_end_s   = win_end_r;
      if (state_r == ST_HOLD) begin
         win_start_s = dump_start;
         win_end_s   = dump_end;
      end else begin
         win_start_s = win_start_r;
         win_end_s   = win_end_r;
      end
      end_hit_s  = (state_r == ST_RUN) && (win_end_r != CYC_ZERO) && (cycle_r == win_end_r);
      dump_nxt_s = ((state_s == ST_RUN) || (state_s == ST_DRAIN)) && (cycle_s >= win_start_s) &&
                   ((win_end_s == CYC_ZERO) || (cycle_s < win_end_s));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         win_start_r <= CYC_ZERO;
         win_end_r   <= CYC_ZERO;
      end else begin
         win_start_r <= win_start_s;
         win_end_r   <= win_end_s;
      end
   end
`else
   logic unused_window_s;
   assign unused_window_s = ^{dump_start, dump_end};
   assign end_hit_s       = 1'b0;
   assign dump_nxt_s      = 1'b0;
`endif

   // event detection, next state and saturating cycle count
   always_comb begin
      state_s    = state_r;
      err_code_s = 2'd0;
      wd_bad_s   = wd_valid && (wd_status != 8'd0) && (wd_status != 8'd255);
      wd_fin_s   = wd_valid && (wd_status == 8'd255) && (tb_done || tb_done_seen_r);
      idle_hit_s = PROG_EN && !progress && (idle_cnt_r == IDLE_LAST);
      if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (cycle_r != CYC_MAX)) begin
         cycle_s = cycle_r + CYCLE_W'(1'b1);
      end else begin
         cycle_s = cycle_r;
      end
      case (state_r)
         ST_HOLD: begin
            if (hold_cnt_r == HOLD_LAST) state_s = ST_RUN;
            else                         state_s = ST_HOLD;
         end
         ST_RUN: begin
            if (wd_bad_s) begin
               state_s    = ST_ERROR;
               err_code_s = 2'd1;
            end else if (end_hit_s) begin
               state_s    = ST_ERROR;
               err_code_s = 2'd3;
            end else if (idle_hit_s) begin
               state_s    = ST_ERROR;
               err_code_s = 2'd2;
            end else if (wd_fin_s) begin
               state_s    = ST_DRAIN;
            end else begin
               state_s    = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (wd_bad_s) begin
               state_s    = ST_ERROR;
               err_code_s = 2'd1;
            end else if (drain_cnt_r == DRAIN_LAST) begin
               state_s    = ST_DONE;
            end else begin
               state_s    = ST_DRAIN;
            end
         end
         ST_DONE:  state_s = ST_DONE;
         ST_ERROR: state_s = ST_ERROR;
         default:  state_s = ST_HOLD;
      endcase
   end

   // state, phase counters and sticky testbench-done latch
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r        <= ST_HOLD;
         hold_cnt_r     <= {HOLD_W{1'b0}};
         idle_cnt_r     <= {IDLE_W{1'b0}};
         drain_cnt_r    <= {DRAIN_W{1'b0}};
         tb_done_seen_r <= 1'b0;
         cycle_r        <= CYC_ZERO;
      end else begin
         state_r <= state_s;
         cycle_r <= cycle_s;
         if ((state_r == ST_HOLD) && (hold_cnt_r != HOLD_LAST))
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
         if (state_r == ST_RUN) begin
            if (progress)                      idle_cnt_r <= {IDLE_W{1'b0}};
            else if (idle_cnt_r != IDLE_LAST)  idle_cnt_r <= idle_cnt_r + IDLE_W'(1'b1);
         end
         if (state_r != ST_DRAIN)              drain_cnt_r <= {DRAIN_W{1'b0}};
         else if (drain_cnt_r != DRAIN_LAST)   drain_cnt_r <= drain_cnt_r + DRAIN_W'(1'b1);
         if ((state_r != ST_HOLD) && tb_done)  tb_done_seen_r <= 1'b1;
      end
   end

   // outputs are registered from the next state so they line up with the state change
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dut_reset_r   <= 1'b1;
         run_active_r  <= 1'b0;
         dump_enable_r <= 1'b0;
         finish_r      <= 1'b0;
         fatal_r       <= 1'b0;
         error_code_r  <= 2'd0;
      end else begin
         dut_reset_r   <= (state_s == ST_HOLD) || (state_s == ST_DONE) || (state_s == ST_ERROR);
         run_active_r  <= (state_s == ST_RUN);
         dump_enable_r <= dump_nxt_s;
         finish_r      <= (state_s == ST_DONE) && (state_r != ST_DONE);
         fatal_r       <= (state_s == ST_ERROR) && (state_r != ST_ERROR);
         if ((state_s == ST_ERROR) && (state_r != ST_ERROR))
            error_code_r <= err_code_s;
      end
   end

   assign dut_reset   = dut_reset_r;
   assign run_active  = run_active_r;
   assign dump_enable = dump_enable_r;
   assign finish      = finish_r;
   assign fatal       = fatal_r;
   assign error_code  = error_code_r;
   assign cycle       = cycle_r;
endmodule

// File: tb/tb_t1_run_sequencer.sv
// Randomized bench for t1_run_sequencer: per-scenario input timelines are scored against an
// event-level outcome model (when and how the run ends) derived from the run rules.
module tb_t1_run_sequencer;
   localparam int RC    = 4;
   localparam int CW    = 8;
   localparam int PL    = 50;
   localparam int DC    = 16;
   localparam int CMAX  = 255;
   localparam int H_MAX = 320;
   localparam int INF   = 32'h3fff_ffff;
`ifdef T1_RUN_TRACE_WINDOW_EN
   localparam bit WIN = 1'b1;
`else
   localparam bit WIN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          wd_valid = 1'b0;
   logic [7:0]    wd_status = 8'd0;
   logic          tb_done = 1'b0;
   logic          progress = 1'b0;
   logic [CW-1:0] dump_start = '0;
   logic [CW-1:0] dump_end = '0;
   logic          dut_reset, run_active, dump_enable, finish, fatal;
   logic [1:0]    error_code;
   logic [CW-1:0] cycle;

   t1_run_sequencer #(.RESET_CYCLES(RC), .CYCLE_W(CW), .PROGRESS_LIMIT(PL), .DRAIN_CYCLES(DC)) dut (
      .clock(clock), .reset(reset), .wd_valid(wd_valid), .wd_status(wd_status), .tb_done(tb_done),
      .progress(progress), .dump_start(dump_start), .dump_end(dump_end), .dut_reset(dut_reset),
      .run_active(run_active), .dump_enable(dump_enable), .finish(finish), .fatal(fatal),
      .error_code(error_code), .cycle(cycle));

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cur_s = 0;
   int cur_p = 0;

   bit         wv [H_MAX];
   logic [7:0] ws [H_MAX];
   bit         td [H_MAX];
   bit         pg [H_MAX];

   // outcome of the current scenario
   int m_T, m_R, m_out, m_code;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s scen=%0d p=%0d got=%0h exp=%0h", tag, cur_s, cur_p, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // walk the run-cycle timeline: first terminating event decides when and how the run ends
   task automatic predict(input int h, input int ds, input int de);
      bit seen, draining, bad, e2, e3;
      int idle, fin_k;
      m_T = INF; m_R = INF; m_out = 0; m_code = 0;
      seen = 1'b0; draining = 1'b0; idle = 0; fin_k = 0;
      for (int k = 0; k < h; k++) begin
         bad = wv[k] && (ws[k] != 8'd0) && (ws[k] != 8'd255);
         if (!draining) begin
            seen = seen | td[k];
            idle = pg[k] ? 0 : idle + 1;
            e2 = (idle >= PL);
            e3 = WIN && (de != 0) && (sat(k) == de);
            if (bad || e2 || e3) begin
               m_out = 2; m_code = bad ? 1 : (e3 ? 3 : 2); m_T = k; m_R = k;
               break;
            end
            if (wv[k] && (ws[k] == 8'd255) && seen) begin
               draining = 1'b1; fin_k = k; m_R = k;
            end
         end else begin
            if (bad) begin
               m_out = 2; m_code = 1; m_T = k;
               break;
            end
            if (k == fin_k + DC) begin
               m_out = 1; m_T = k;
               break;
            end
         end
      end
   endtask

   initial begin
      int kind, h, ds, de, tk, fk, bk, k0, last, ecyc;
      bit active;
      for (int s = 0; s < 30; s++) begin
         cur_s = s;
         kind  = s % 6;
         h     = 120;
         for (int k = 0; k < H_MAX; k++) begin
            wv[k] = ($urandom_range(0, 9) == 0);
            ws[k] = 8'd0;
            td[k] = 1'b0;
            pg[k] = ($urandom_range(0, 99) < 40);
         end
         ds = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
         de = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 90);
         case (kind)
            0, 1: begin
               tk = $urandom_range(3, 40);
               td[tk] = 1'b1;
               wv[tk-2] = 1'b1; ws[tk-2] = 8'd255;
               fk = tk + $urandom_range(0, 30);
               wv[fk] = 1'b1; ws[fk] = 8'd255;
               if (kind == 1) begin
                  bk = $urandom_range(2, fk + 20);
                  wv[bk] = 1'b1; ws[bk] = 8'($urandom_range(1, 254));
               end
            end
            2: begin
               k0 = $urandom_range(0, 40);
               for (int k = 0; k < H_MAX; k++) begin
                  wv[k] = 1'b0;
                  if (k >= k0) pg[k] = 1'b0;
               end
               h = k0 + 90;
            end
            3, 4: begin
               for (int k = 0; k < H_MAX; k++) begin
                  wv[k] = 1'b0;
                  pg[k] = (kind == 3) ? ((k % 50) == 49) : ((k % 51) == 50);
               end
               td[150] = 1'b1;
               wv[190] = 1'b1; ws[190] = 8'd255;
               de = 0;
               h = 230;
            end
            default: begin
               for (int k = 0; k < H_MAX; k++) begin
                  wv[k] = 1'b0;
                  pg[k] = ($urandom_range(0, 99) < 60);
                  td[k] = ($urandom_range(0, 19) == 0);
               end
               de = 0;
               h = 300;
            end
         endcase
         predict(h, ds, de);

         // reset may land mid-run: everything must return at once
         @(negedge clock);
         reset = 1'b1;
         cur_p = -99;
         #1;
         check_val("rst_dut_reset", dut_reset, 1);
         check_val("rst_run_active", run_active, 0);
         check_val("rst_finish", finish, 0);
         check_val("rst_fatal", fatal, 0);
         check_val("rst_error_code", error_code, 0);
         check_val("rst_cycle", cycle, 0);
         check_val("rst_dump_enable", dump_enable, 0);

         last = (m_T + 4 < h) ? m_T + 4 : h;
         for (int p = -RC; p < last; p++) begin
            @(negedge clock);
            cur_p = p;
            if (p == -RC) reset = 1'b0;
            active = (p >= 0) && (p <= m_T);
            ecyc = (p < 0) ? 0 : sat((p <= m_T) ? p : m_T + 1);
            check_val("dut_reset", dut_reset, !active);
            check_val("run_active", run_active, (p >= 0) && (p <= m_R));
            check_val("cycle", cycle, ecyc);
            check_val("finish", finish, (m_out == 1) && (p == m_T + 1));
            check_val("fatal", fatal, (m_out == 2) && (p == m_T + 1));
            check_val("error_code", error_code, ((m_out == 2) && (p > m_T)) ? m_code : 0);
            check_val("dump_enable", dump_enable,
                      WIN && active && (sat(p) >= ds) && ((de == 0) || (sat(p) < de)));
            if (p < 0) begin
               wd_valid   = 1'($urandom_range(0, 1));
               wd_status  = 8'($urandom_range(0, 255));
               tb_done    = 1'($urandom_range(0, 1));
               progress   = 1'($urandom_range(0, 1));
               dump_start = (p == -1) ? CW'(ds) : CW'($urandom_range(0, 255));
               dump_end   = (p == -1) ? CW'(de) : CW'($urandom_range(0, 255));
            end else begin
               wd_valid   = wv[p];
               wd_status  = ws[p];
               tb_done    = td[p];
               progress   = pg[p];
               dump_start = CW'($urandom_range(0, 255));
               dump_end   = CW'($urandom_range(0, 255));
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
